iotdf_sched: RTL

Round-based scheduler that shares one IOT data-filter engine between NREQ sensor requesters. It grants one requester at a time for a complete filter round of 8 records × 16 bytes and streams that requester's bytes into the engine under the engine's `busy` handshake. It drives the engine's function select, counts the engine's result pulses, and returns a per-requester completion pulse. Sits between the sensor FIFOs and the filter engine in the IOTDF subsystem.

---
 rtl/iotdf_sched.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/iotdf_sched.sv
// rtl/iotdf_sched.sv - round-based scheduler sharing one IOT data-filter engine between NREQ requesters
//
// Grants one requester at a time for a full round of 8 records x 16 bytes,
// streams its bytes into the engine under the engine's busy handshake, drives
// fn_sel for the round, counts engine result pulses and pulses done[g] at the
// end of the drain window.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req[NREQ]           requester i has a full 128-byte round queued
//   fn_req[3*NREQ]      function code per requester, lane i at [3i+2:3i]
//   rd_vld[NREQ]        requester FWFT byte lane non-empty
//   rd_data[8*NREQ]     requester current byte, lane i at [8i+7:8i]
//   rd_en[NREQ]         pop one byte from the granted requester
//   grant[NREQ]         one-hot, held for the whole round
//   done[NREQ]          one-cycle round-complete pulse
//   vld_cnt[4]          engine valid pulses in the finished round (valid with done)
//   err                 padded-round flag, coincident with done
//   in_en, iot_in[8]    byte strobe and byte to the engine
//   fn_sel[3]           registered function select to the engine
//   busy, eng_valid     engine busy and result strobe
//
// Build option: SCHED_TIMEOUT_EN enables the stall timeout with zero padding;
// without it the block waits on rd_vld indefinitely and err is tied low.

module iotdf_sched #(
    parameter int NREQ      = 4,
    parameter int DRAIN_CYC = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   fn_req,
    input  logic [NREQ-1:0]     rd_vld,
    input  logic [8*NREQ-1:0]   rd_data,
    output logic [NREQ-1:0]     rd_en,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic [3:0]          vld_cnt,
    output logic                err,
    output logic                in_en,
    output logic [7:0]          iot_in,
    output logic [2:0]          fn_sel,
    input  logic                busy,
    input  logic                eng_valid
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_STREAM, S_DRAIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [GW-1:0]  ptr;
    logic [GW-1:0]  gidx;
    logic [6:0]     bcnt;
    logic [3:0]     ecnt;
    logic [3:0]     ecnt_inc;
    logic [DW-1:0]  dcnt;
    logic           arb_hit;
    logic [GW-1:0]  arb_idx;
    logic           lane_vld;
    logic           xfer;
    logic           drain_last;
    logic           pad;

    // Round-robin search from ptr+1. Scanning from the far end toward the
    // near end lets the nearest requester overwrite the result, so the
    // requester that just finished (offset NREQ) is chosen only if alone.
    always_comb begin
        int cand;
        cand    = 0;
        arb_hit = 1'b0;
        arb_idx = ptr;
        for (int i = NREQ; i >= 1; i--) begin
            cand = (int'(ptr) + i) % NREQ;
            if (req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = GW'(cand);
            end
        end
    end

    always_comb begin
        lane_vld   = rd_vld[gidx];
        // In pad mode bytes go out on !busy alone; rd_vld no longer matters.
        xfer       = (state == S_STREAM) && !busy && (pad || lane_vld);
        drain_last = (state == S_DRAIN) && (dcnt == DW'(DRAIN_CYC - 1));
        ecnt_inc   = (eng_valid && ecnt != 4'hF) ? ecnt + 4'd1 : ecnt;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_ARB;
            S_ARB:    if (arb_hit) state_nxt = S_STREAM;
            S_STREAM: if (xfer && bcnt == 7'd127) state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_last) state_nxt = S_ARB;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_en   = xfer;
        iot_in  = (xfer && !pad) ? rd_data[8*int'(gidx) +: 8] : 8'h00;
        rd_en   = grant & {NREQ{xfer && !pad}};
        done    = drain_last ? grant : '0;
        vld_cnt = drain_last ? ecnt_inc : 4'd0;
        err     = drain_last && pad;
    end

    // Round datapath: grant/fn_sel capture, byte, engine-result and drain counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= GW'(NREQ - 1);
            gidx   <= '0;
            grant  <= '0;
            fn_sel <= 3'd0;
            bcnt   <= 7'd0;
            ecnt   <= 4'd0;
            dcnt   <= '0;
        end else begin
            case (state)
                S_ARB: begin
                    if (arb_hit) begin
                        gidx   <= arb_idx;
                        grant  <= NREQ'(1) << arb_idx;
                        fn_sel <= fn_req[3*int'(arb_idx) +: 3];
                        bcnt   <= 7'd0;
                        ecnt   <= 4'd0;
                    end
                end
                S_STREAM: begin
                    ecnt <= ecnt_inc;
                    if (xfer) begin
                        bcnt <= bcnt + 7'd1;
                        if (bcnt == 7'd127) begin
                            dcnt <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    ecnt <= ecnt_inc;
                    dcnt <= dcnt + 1'b1;
                    if (drain_last) begin
                        grant <= '0;
                        ptr   <= gidx;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall;

    // Counts consecutive cycles with the granted lane empty; once TIMEOUT is
    // reached the rest of the round is padded with zero bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad   <= 1'b0;
            stall <= '0;
        end else if (state == S_ARB) begin
            pad   <= 1'b0;
            stall <= '0;
        end else if (state == S_STREAM && !pad) begin
            if (lane_vld) begin
                stall <= '0;
            end else if (stall == SW'(TIMEOUT - 1)) begin
                pad <= 1'b1;
            end else begin
                stall <= stall + 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign pad            = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

endmodule
